pic_priority_core: RTL and testbench

- Clocked, parametrised successor to the PIC control logic. Generalises channel count beyond 8, adds a real IRR/ISR/IMR datapath, a priority resolver and a synchronous two-pulse INTA sequencer.
- Sits between the read/write decode logic (byte writes in) and the CPU interface (INT out, vector out on the second INTA).
- Single-chip mode only; cascade is out of scope.

---
 rtl/pic_priority_core.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_pic_priority_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pic_priority_core.sv
`default_nettype none
// ============================================================================
//  Module      : pic_priority_core
//  Description : Parametrised PIC core. IRR/ISR/IMR datapath, rotating
//                priority resolver, init-word sequencer and a synchronous
//                two-pulse INTA sequencer. Single-chip mode only.
//                Optional macro PIC_ROTATE_EN enables priority rotation.
//  Revision    : 1.0  initial release
// ============================================================================
module pic_priority_core #(
    parameter int N_IR  = 8,
    parameter int LOG_N = $clog2(N_IR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IR-1:0]  ir_in,
    input  logic             wr_stb,
    input  logic             a0,
    input  logic [7:0]       data_in,
    input  logic             inta_n,
    output logic             int_out,
    output logic [7:0]       vector_out,
    output logic             vector_valid,
    output logic [N_IR-1:0]  irr_out,
    output logic [N_IR-1:0]  isr_out,
    output logic [N_IR-1:0]  imr_out
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ICW2 = 2'd1,
        WAIT_ICW4 = 2'd2,
        READY     = 2'd3
    } init_state_t;

    typedef enum logic [1:0] {
        ACK_IDLE = 2'd0,
        ACK1     = 2'd1,
        ACK2     = 2'd2
    } ack_state_t;

    init_state_t            r_init_state, w_init_next;
    ack_state_t             r_ack_state,  w_ack_next;

    logic [N_IR-1:0]        r_ir_q;
    logic [N_IR-1:0]        r_irr;
    logic [N_IR-1:0]        r_isr;
    logic [N_IR-1:0]        r_imr;
    logic                   r_ltim;
    logic                   r_ic4;
    logic                   r_aeoi;
    logic [7-LOG_N:0]       r_base;
    logic [LOG_N-1:0]       r_winner;
    logic                   r_spurious;
    logic                   r_inta_n_q;

    logic                   w_icw1, w_icw2, w_icw4, w_ocw1, w_ocw2;
    logic                   w_eoi, w_sl;
    logic [LOG_N-1:0]       w_lvl;
    logic [N_IR-1:0]        w_imr_wdata;
    logic [LOG_N-1:0]       w_lowest_prio;
    logic [N_IR-1:0]        w_req;
    logic                   w_req_found, w_isr_found;
    logic [LOG_N-1:0]       w_req_ch, w_isr_ch, w_req_rank, w_isr_rank;
    logic [LOG_N-1:0]       w_scan_ch;
    logic                   w_fall, w_ack1, w_ack2;
    logic [N_IR-1:0]        w_isr_set, w_isr_clr, w_irr_clr;
    logic                   w_int;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign w_icw1 = wr_stb & ~a0 & data_in[4];
    assign w_icw2 = wr_stb &  a0 & (r_init_state == WAIT_ICW2);
    assign w_icw4 = wr_stb &  a0 & (r_init_state == WAIT_ICW4);
    assign w_ocw1 = wr_stb &  a0 & (r_init_state == READY);
    assign w_ocw2 = wr_stb & ~a0 & (data_in[4:3] == 2'b00) & (r_init_state == READY);
    assign w_eoi  = data_in[5];
    assign w_sl   = data_in[6];
    assign w_lvl  = data_in[LOG_N-1:0];

    // Wide masks arrive a byte at a time, alternating low then high byte.
    generate
        if (N_IR > 8) begin : g_imr_wide
            logic r_imr_hi;
            // Byte-select toggle, restarted by every ICW1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      r_imr_hi <= 1'b0;
                else if (w_icw1) r_imr_hi <= 1'b0;
                else if (w_ocw1) r_imr_hi <= ~r_imr_hi;
            end
            assign w_imr_wdata = r_imr_hi ? {data_in[N_IR-9:0], r_imr[7:0]}
                                          : {r_imr[N_IR-1:8], data_in};
        end else begin : g_imr_narrow
            assign w_imr_wdata = data_in[N_IR-1:0];
        end
    endgenerate

    // Init sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_init_state <= IDLE;
        else        r_init_state <= w_init_next;
    end

    // Init sequencer next state; ICW1 restarts from any state
    always_comb begin
        w_init_next = r_init_state;
        if (w_icw1) begin
            w_init_next = WAIT_ICW2;
        end else begin
            case (r_init_state)
                WAIT_ICW2: if (wr_stb && a0) w_init_next = r_ic4 ? WAIT_ICW4 : READY;
                WAIT_ICW4: if (wr_stb && a0) w_init_next = READY;
                default:   w_init_next = r_init_state;
            endcase
        end
    end

    // Configuration latched from the init words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ltim <= 1'b0;
            r_ic4  <= 1'b0;
            r_aeoi <= 1'b0;
            r_base <= '0;
        end else begin
            if (w_icw1) begin
                r_ltim <= data_in[3];
                r_ic4  <= data_in[0];
                r_aeoi <= 1'b0;
            end
            if (w_icw2) r_base <= data_in[7:LOG_N];
            if (w_icw4) r_aeoi <= data_in[1];
        end
    end

    // ------------------------------------------------------------------
    // Priority rotation pointer
    // ------------------------------------------------------------------
`ifdef PIC_ROTATE_EN
    logic [LOG_N-1:0] r_lowest_prio;
    logic             r_auto_rot;
    logic             w_rot;
    assign w_rot = data_in[7];

    // Rotation pointer and auto-rotate mode, updated by OCW2 and AEOI completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lowest_prio <= LOG_N'(N_IR-1);
            r_auto_rot    <= 1'b0;
        end else if (w_icw1) begin
            r_auto_rot    <= 1'b0;
        end else begin
            if (w_ack2 && r_aeoi && !r_spurious && r_auto_rot)
                r_lowest_prio <= r_winner;
            if (w_ocw2) begin
                if (w_eoi) begin
                    if (w_rot) begin
                        if (w_sl)             r_lowest_prio <= w_lvl;
                        else if (w_isr_found) r_lowest_prio <= w_isr_ch;
                    end
                end else if (w_sl) begin
                    if (w_rot) r_lowest_prio <= w_lvl;
                end else begin
                    r_auto_rot <= w_rot;
                end
            end
        end
    end
    assign w_lowest_prio = r_lowest_prio;
`else
    assign w_lowest_prio = LOG_N'(N_IR-1);
`endif

    // ------------------------------------------------------------------
    // Priority resolver: rank 0 is channel lowest_prio+1, descending with wrap
    // ------------------------------------------------------------------
    assign w_req = r_irr & ~r_imr;

    // Scan from lowest to highest priority so the highest-ranked hit sticks
    always_comb begin
        w_req_found = 1'b0;
        w_isr_found = 1'b0;
        w_req_ch    = '0;
        w_isr_ch    = '0;
        w_req_rank  = '0;
        w_isr_rank  = '0;
        w_scan_ch   = '0;
        for (int i = N_IR-1; i >= 0; i--) begin
            w_scan_ch = w_lowest_prio + LOG_N'(i + 1);
            if (w_req[w_scan_ch]) begin
                w_req_found = 1'b1;
                w_req_ch    = w_scan_ch;
                w_req_rank  = LOG_N'(i);
            end
            if (r_isr[w_scan_ch]) begin
                w_isr_found = 1'b1;
                w_isr_ch    = w_scan_ch;
                w_isr_rank  = LOG_N'(i);
            end
        end
    end

    // Fully nested: only a request strictly above every in-service level interrupts
    assign w_int = (r_init_state == READY) && w_req_found &&
                   (!w_isr_found || (w_req_rank < w_isr_rank));

    // ------------------------------------------------------------------
    // INTA sequencer
    // ------------------------------------------------------------------
    assign w_fall = r_inta_n_q & ~inta_n;

    // Acknowledge state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ack_state <= ACK_IDLE;
        else        r_ack_state <= w_ack_next;
    end

    // Acknowledge next state and the per-pulse action strobes
    always_comb begin
        w_ack_next = r_ack_state;
        w_ack1     = 1'b0;
        w_ack2     = 1'b0;
        case (r_ack_state)
            ACK_IDLE: if (w_fall) begin w_ack_next = ACK1; w_ack1 = 1'b1; end
            ACK1:     if (w_fall) begin w_ack_next = ACK2; w_ack2 = 1'b1; end
            ACK2:     w_ack_next = ACK_IDLE;
            default:  w_ack_next = ACK_IDLE;
        endcase
    end

    // Winner freeze on the first pulse, vector delivery on the second
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inta_n_q   <= 1'b1;
            r_winner     <= '0;
            r_spurious   <= 1'b0;
            vector_out   <= 8'h00;
            vector_valid <= 1'b0;
            int_out      <= 1'b0;
        end else begin
            r_inta_n_q   <= inta_n;
            vector_valid <= w_ack2;
            int_out      <= w_int;
            if (w_ack1) begin
                r_winner   <= w_req_found ? w_req_ch : LOG_N'(N_IR-1);
                r_spurious <= ~w_req_found;
            end
            if (w_ack2) vector_out <= {r_base, r_winner};
        end
    end

    // ------------------------------------------------------------------
    // IRR / ISR / IMR
    // ------------------------------------------------------------------
    // Set and clear masks; an INTA set overrides a coincident EOI clear
    always_comb begin
        w_isr_set = '0;
        w_isr_clr = '0;
        w_irr_clr = '0;
        if (w_ack1 && w_req_found) begin
            w_isr_set[w_req_ch] = 1'b1;
            w_irr_clr[w_req_ch] = 1'b1;
        end
        if (w_ack2 && r_aeoi && !r_spurious)
            w_isr_clr[r_winner] = 1'b1;
        if (w_ocw2 && w_eoi) begin
            if (w_sl)             w_isr_clr[w_lvl]    = 1'b1;
            else if (w_isr_found) w_isr_clr[w_isr_ch] = 1'b1;
        end
    end

    // Request, in-service and mask registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_q <= '0;
            r_irr  <= '0;
            r_isr  <= '0;
            r_imr  <= '1;
        end else begin
            r_ir_q <= ir_in;
            if (w_icw1) begin
                r_irr <= '0;
                r_isr <= '0;
                r_imr <= '0;
            end else begin
                r_irr <= (r_ltim ? ir_in : (r_irr | (ir_in & ~r_ir_q))) & ~w_irr_clr;
                r_isr <= (r_isr & ~w_isr_clr) | w_isr_set;
                if (w_ocw1) r_imr <= w_imr_wdata;
            end
        end
    end

    assign irr_out = r_irr;
    assign isr_out = r_isr;
    assign imr_out = r_imr;

endmodule
`default_nettype wire

// File: tb/tb_pic_priority_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pic_priority_core
//  Description : Directed self-checking bench; an 8-channel and a 16-channel
//                core share the write/INTA bus and have separate IR inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pic_priority_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_stb = 1'b0;
    logic        a0 = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        inta_n = 1'b1;
    logic [7:0]  ir8 = 8'h00;
    logic [15:0] ir16 = 16'h0000;

    logic        int8, vv8, int16, vv16;
    logic [7:0]  vec8, vec16;
    logic [7:0]  irr8, isr8, imr8;
    logic [15:0] irr16, isr16, imr16;

    int n_tests = 0;
    int n_fail  = 0;

    pic_priority_core #(.N_IR(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ir_in(ir8), .wr_stb(wr_stb), .a0(a0),
        .data_in(data_in), .inta_n(inta_n), .int_out(int8), .vector_out(vec8),
        .vector_valid(vv8), .irr_out(irr8), .isr_out(isr8), .imr_out(imr8)
    );

    pic_priority_core #(.N_IR(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .ir_in(ir16), .wr_stb(wr_stb), .a0(a0),
        .data_in(data_in), .inta_n(inta_n), .int_out(int16), .vector_out(vec16),
        .vector_valid(vv16), .irr_out(irr16), .isr_out(isr16), .imr_out(imr16)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk); wr_stb = 1'b1; a0 = a; data_in = d;
        @(negedge clk); wr_stb = 1'b0; a0 = 1'b0; data_in = 8'h00;
    endtask

    // Drop INTA; returns just after the edge that sampled the falling edge
    task automatic inta_low();
        @(negedge clk); inta_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic inta_high();
        inta_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic init8(input logic [7:0] icw1, input logic [7:0] icw2, input logic [7:0] icw4);
        wr(1'b0, icw1); wr(1'b1, icw2); wr(1'b1, icw4);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (int8 !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", int8); end
        n_tests++; if (vec8 !== 8'h00) begin n_fail++; $display("FAIL reset_vec: got %h want 00", vec8); end
        n_tests++; if (vv8 !== 1'b0) begin n_fail++; $display("FAIL reset_vv: got %b want 0", vv8); end
        n_tests++; if (irr8 !== 8'h00 || isr8 !== 8'h00) begin n_fail++; $display("FAIL reset_irr_isr: got %h/%h want 00/00", irr8, isr8); end
        n_tests++; if (imr8 !== 8'hFF) begin n_fail++; $display("FAIL reset_imr8: got %h want ff", imr8); end
        n_tests++; if (imr16 !== 16'hFFFF) begin n_fail++; $display("FAIL reset_imr16: got %h want ffff", imr16); end
        // OCW1-shaped write while still uninitialised must be ignored
        wr(1'b1, 8'h00);
        n_tests++; if (imr8 !== 8'hFF) begin n_fail++; $display("FAIL idle_write_ignored: got %h want ff", imr8); end
    endtask

    task automatic test_init_ack();
        init8(8'h11, 8'h40, 8'h01);
        wr(1'b1, 8'h00);
        n_tests++; if (imr8 !== 8'h00) begin n_fail++; $display("FAIL init_imr: got %h want 00", imr8); end
        @(negedge clk); ir8 = 8'h08;
        @(negedge clk); ir8 = 8'h00;
        n_tests++; if (irr8 !== 8'h08) begin n_fail++; $display("FAIL init_irr: got %h want 08", irr8); end
        @(negedge clk);
        n_tests++; if (int8 !== 1'b1) begin n_fail++; $display("FAIL init_int: got %b want 1", int8); end
        inta_low();
        n_tests++; if (isr8 !== 8'h08 || irr8 !== 8'h00) begin n_fail++; $display("FAIL ack1_isr_irr: got %h/%h want 08/00", isr8, irr8); end
        inta_high();
        n_tests++; if (vv8 !== 1'b0) begin n_fail++; $display("FAIL ack1_no_vv: got %b want 0", vv8); end
        inta_low();
        n_tests++; if (vv8 !== 1'b1 || vec8 !== 8'h43) begin n_fail++; $display("FAIL ack2_vector: got vv=%b vec=%h want 1/43", vv8, vec8); end
        inta_high();
        n_tests++; if (vv8 !== 1'b0) begin n_fail++; $display("FAIL ack2_vv_one_cycle: got %b want 0", vv8); end
        n_tests++; if (isr8 !== 8'h08) begin n_fail++; $display("FAIL ack2_isr: got %h want 08", isr8); end
    endtask

    task automatic test_nested();
        @(negedge clk); ir8 = 8'h20;
        repeat (3) @(negedge clk);
        n_tests++; if (int8 !== 1'b0 || irr8 !== 8'h20) begin n_fail++; $display("FAIL nested_lower: got int=%b irr=%h want 0/20", int8, irr8); end
        ir8 = 8'h22;
        repeat (2) @(negedge clk);
        n_tests++; if (int8 !== 1'b1) begin n_fail++; $display("FAIL nested_higher_int: got %b want 1", int8); end
        inta_low(); inta_high();
        inta_low();
        n_tests++; if (vv8 !== 1'b1 || vec8 !== 8'h41) begin n_fail++; $display("FAIL nested_vector: got vv=%b vec=%h want 1/41", vv8, vec8); end
        inta_high();
        n_tests++; if (isr8 !== 8'h0A || irr8 !== 8'h20) begin n_fail++; $display("FAIL nested_isr_irr: got %h/%h want 0a/20", isr8, irr8); end
        wr(1'b0, 8'h20);
        n_tests++; if (isr8 !== 8'h08) begin n_fail++; $display("FAIL nonspec_eoi: got %h want 08", isr8); end
        repeat (2) @(negedge clk);
        n_tests++; if (int8 !== 1'b0) begin n_fail++; $display("FAIL nested_after_eoi_int: got %b want 0", int8); end
    endtask

    task automatic test_mask_spurious();
        wr(1'b1, 8'hFF);
        @(negedge clk); ir8 = 8'h26;
        repeat (3) @(negedge clk);
        n_tests++; if (int8 !== 1'b0 || irr8 !== 8'h24) begin n_fail++; $display("FAIL masked: got int=%b irr=%h want 0/24", int8, irr8); end
        inta_low(); inta_high();
        inta_low();
        n_tests++; if (vv8 !== 1'b1 || vec8 !== 8'h47) begin n_fail++; $display("FAIL spurious_vector: got vv=%b vec=%h want 1/47", vv8, vec8); end
        inta_high();
        n_tests++; if (isr8 !== 8'h08 || irr8 !== 8'h24) begin n_fail++; $display("FAIL spurious_isr_irr: got %h/%h want 08/24", isr8, irr8); end
        ir8 = 8'h00;
    endtask

    task automatic test_aeoi_level();
        init8(8'h19, 8'h80, 8'h03);
        @(negedge clk); ir8 = 8'h40;
        repeat (2) @(negedge clk);
        n_tests++; if (int8 !== 1'b1) begin n_fail++; $display("FAIL level_int: got %b want 1", int8); end
        inta_low();
        n_tests++; if (isr8 !== 8'h40) begin n_fail++; $display("FAIL aeoi_ack1_isr: got %h want 40", isr8); end
        inta_high();
        inta_low();
        n_tests++; if (vv8 !== 1'b1 || vec8 !== 8'h86 || isr8 !== 8'h00) begin n_fail++; $display("FAIL aeoi_ack2: got vv=%b vec=%h isr=%h want 1/86/00", vv8, vec8, isr8); end
        inta_high();
        n_tests++; if (int8 !== 1'b1 || irr8 !== 8'h40) begin n_fail++; $display("FAIL level_reassert: got int=%b irr=%h want 1/40", int8, irr8); end
        ir8 = 8'h00;
    endtask

    task automatic test_n16();
        init8(8'h11, 8'h20, 8'h01);
        @(negedge clk); ir16 = 16'h1000;
        @(negedge clk); ir16 = 16'h0000;
        @(negedge clk);
        n_tests++; if (int16 !== 1'b1 || irr16 !== 16'h1000) begin n_fail++; $display("FAIL n16_int: got int=%b irr=%h want 1/1000", int16, irr16); end
        inta_low(); inta_high();
        inta_low();
        n_tests++; if (vv16 !== 1'b1 || vec16 !== 8'h2C) begin n_fail++; $display("FAIL n16_vector: got vv=%b vec=%h want 1/2c", vv16, vec16); end
        inta_high();
        n_tests++; if (isr16 !== 16'h1000) begin n_fail++; $display("FAIL n16_isr: got %h want 1000", isr16); end
        wr(1'b1, 8'h00);
        wr(1'b1, 8'h10);
        n_tests++; if (imr16 !== 16'h1000) begin n_fail++; $display("FAIL n16_imr_bytes: got %h want 1000", imr16); end
        n_tests++; if (imr8 !== 8'h10) begin n_fail++; $display("FAIL n8_imr_last: got %h want 10", imr8); end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_vec;
        logic [7:0] exp_isr;
`ifdef PIC_ROTATE_EN
        exp_vec = 8'h44; exp_isr = 8'h10;
`else
        exp_vec = 8'h43; exp_isr = 8'h08;
`endif
        init8(8'h11, 8'h40, 8'h01);
        @(negedge clk); ir8 = 8'h08;
        @(negedge clk); ir8 = 8'h00;
        inta_low(); inta_high(); inta_low(); inta_high();
        n_tests++; if (isr8 !== 8'h08) begin n_fail++; $display("FAIL rot_pre_isr: got %h want 08", isr8); end
        wr(1'b0, 8'hE3);
        n_tests++; if (isr8 !== 8'h00) begin n_fail++; $display("FAIL specific_eoi: got %h want 00", isr8); end
        @(negedge clk); ir8 = 8'h18;
        @(negedge clk); ir8 = 8'h00;
        n_tests++; if (irr8 !== 8'h18) begin n_fail++; $display("FAIL rot_irr: got %h want 18", irr8); end
        inta_low(); inta_high();
        inta_low();
        n_tests++; if (vv8 !== 1'b1 || vec8 !== exp_vec) begin n_fail++; $display("FAIL rot_vector: got vv=%b vec=%h want 1/%h", vv8, vec8, exp_vec); end
        inta_high();
        n_tests++; if (isr8 !== exp_isr) begin n_fail++; $display("FAIL rot_isr: got %h want %h", isr8, exp_isr); end
    endtask

    task automatic test_reset_mid_inta();
        @(negedge clk); ir8 = 8'h01;
        @(negedge clk); ir8 = 8'h00;
        inta_low(); inta_high();
        n_tests++; if (isr8[0] !== 1'b1) begin n_fail++; $display("FAIL mid_ack1_isr0: got %b want 1", isr8[0]); end
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (isr8 !== 8'h00 || irr8 !== 8'h00 || imr8 !== 8'hFF || int8 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_regs: got isr=%h irr=%h imr=%h int=%b want 00/00/ff/0", isr8, irr8, imr8, int8); end
        inta_low();
        n_tests++; if (vv8 !== 1'b0 || vec8 !== 8'h00) begin n_fail++; $display("FAIL mid_reset_aborted: got vv=%b vec=%h want 0/00", vv8, vec8); end
        inta_high();
    endtask

    initial begin
        test_reset();
        test_init_ack();
        test_nested();
        test_mask_spurious();
        test_aeoi_level();
        test_n16();
        test_rotate();
        test_reset_mid_inta();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
